// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, header defaults.
package uart_pkg;

  localparam int unsigned MAX_SRC   = 8;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HDR_IDX_W = 3;
  localparam logic [4:0]  HDR_TAG_DEF = 5'b10100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2
  } arb_state_t;

  // Header byte: tag in the upper bits, source index in the lower bits.
  function automatic logic [BYTE_W-1:0] hdr_byte(input logic [4:0] tag,
                                                 input logic [HDR_IDX_W-1:0] idx);
    return {tag, idx};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, wrapping at N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  int unsigned cand;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = (32'(ptr) + i) % N;
      if (!found && req[IW'(cand)]) begin
        idx   = IW'(cand);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte emitter among N sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter bit          HDR_EN  = 1'b1,
  parameter logic [4:0]  HDR_TAG = HDR_TAG_DEF,
  parameter int unsigned MAX_LEN = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [BYTE_W*N_SRC-1:0]   i_req_data,
  input  logic [N_SRC-1:0]          i_req_valid,
  input  logic [N_SRC-1:0]          i_req_last,
  output logic [N_SRC-1:0]          o_req_ready,
  output logic [BYTE_W-1:0]         o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [N_SRC-1:0]          o_grant,
  output logic                      o_busy,
  output logic                      o_trunc
);

  localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CW = $clog2(MAX_LEN + 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                trunc_q, trunc_d;

  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic [BYTE_W-1:0]   src_byte [N_SRC];
  logic [BYTE_W-1:0]   g_data;
  logic                g_valid;
  logic                g_last;
  logic [CW-1:0]       cnt_inc;
  logic                at_max;

  rr_pick #(.N(N_SRC), .IW(IW)) u_rr_pick (
    .req   (i_req_valid),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Split the flat source bus into bytes and select the granted source.
  always_comb begin
    for (int unsigned k = 0; k < N_SRC; k++) begin
      src_byte[k] = i_req_data[k*BYTE_W +: BYTE_W];
    end
    g_data  = src_byte[gidx_q];
    g_valid = i_req_valid[gidx_q];
    g_last  = i_req_last[gidx_q];
    cnt_inc = cnt_q + CW'(1);
    at_max  = (cnt_inc == CW'(MAX_LEN));
  end

  // Next-state, grant bookkeeping and emitter-side muxing.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    trunc_d     = 1'b0;
    o_data      = '0;
    o_valid     = 1'b0;
    o_req_ready = '0;
    o_grant     = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = HDR_EN ? ST_HDR : ST_SEND;
        end
      end
      ST_HDR: begin
        o_valid = 1'b1;
        o_data  = hdr_byte(HDR_TAG, HDR_IDX_W'(gidx_q));
        o_grant = N_SRC'(1) << gidx_q;
        if (i_ready) state_d = ST_SEND;
      end
      ST_SEND: begin
        o_data              = g_data;
        o_valid             = g_valid;
        o_req_ready[gidx_q] = i_ready;
        o_grant             = N_SRC'(1) << gidx_q;
        if (g_valid && i_ready) begin
          cnt_d = cnt_inc;
          if (g_last || at_max) begin
            state_d = ST_IDLE;
            rr_d    = (gidx_q == IW'(N_SRC - 1)) ? '0 : gidx_q + IW'(1);
            trunc_d = !g_last;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy  = (state_q != ST_IDLE);
  assign o_trunc = trunc_q;

  // State and grant registers; reset abandons any packet in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: source models, byte scoreboard, per-scenario tasks.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 4;

  logic             i_clk;
  logic             i_rst_n;
  logic [8*N-1:0]   i_req_data;
  logic [N-1:0]     i_req_valid;
  logic [N-1:0]     i_req_last;
  logic [N-1:0]     o_req_ready;
  logic [7:0]       o_data;
  logic             o_valid;
  logic             i_ready;
  logic [N-1:0]     o_grant;
  logic             o_busy;
  logic             o_trunc;

  uart_tx_arbiter #(
    .N_SRC   (N),
    .HDR_EN  (1'b1),
    .HDR_TAG (5'b10100),
    .MAX_LEN (MAXL)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_data  (i_req_data),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_trunc     (o_trunc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Source byte buffers: bit 8 = last flag.
  logic [8:0]  src_buf [N][16];
  int          src_rd  [N];
  int          src_wr  [N];
  bit          stall   [N];
  logic [N-1:0] acc;
  bit          rdy_mode;
  bit          mon_en;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  int          n_checks;
  int          n_pass;

  task automatic push_src(input int k, input logic [7:0] d, input bit last);
    src_buf[k][src_wr[k]] = {last, d};
    src_wr[k]++;
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < N; k++) begin
      src_rd[k] = 0;
      src_wr[k] = 0;
      stall[k]  = 1'b0;
    end
    acc = '0;
  endtask

  // Source and emitter-ready drivers, updated just after each rising edge.
  always @(posedge i_clk) begin
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k]) src_rd[k]++;
      if (src_rd[k] < src_wr[k] && !stall[k]) begin
        i_req_valid[k]        = 1'b1;
        i_req_data[8*k +: 8]  = src_buf[k][src_rd[k]][7:0];
        i_req_last[k]         = src_buf[k][src_rd[k]][8];
      end else begin
        i_req_valid[k]        = 1'b0;
        i_req_data[8*k +: 8]  = 8'h00;
        i_req_last[k]         = 1'b0;
      end
    end
    acc     = '0;
    i_ready = rdy_mode ? ~i_ready : 1'b1;
  end

  // Monitor on the falling edge: handshakes and scoreboard of emitted bytes.
  always @(negedge i_clk) begin
    acc = i_req_valid & o_req_ready;
    if (mon_en) begin
      if (o_req_ready != '0) begin
        n_checks++;
        if ((o_req_ready & ~o_grant) != '0)
          $display("FAIL ready_not_granted: ready=%b grant=%b", o_req_ready, o_grant);
        else n_pass++;
      end
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_byte: got %h expected none", o_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (o_data !== mon_exp)
            $display("FAIL byte_stream: got %h expected %h", o_data, mon_exp);
          else n_pass++;
        end
      end
    end
  end

  task automatic apply_reset();
    mon_en  = 1'b0;
    i_rst_n = 1'b0;
    clear_srcs();
    rdy_mode = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_reset();
    mon_en  = 1'b0;
    i_rst_n = 1'b0;
    #3;
    n_checks++;
    if ({o_valid, o_busy, o_trunc, o_grant, o_req_ready, o_data} !== '0)
      $display("FAIL reset_outputs: got v=%b b=%b t=%b g=%b r=%b d=%h expected all 0",
               o_valid, o_busy, o_trunc, o_grant, o_req_ready, o_data);
    else n_pass++;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_valid, o_busy, o_grant} !== '0)
      $display("FAIL idle_after_reset: got v=%b b=%b g=%b expected 0", o_valid, o_busy, o_grant);
    else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int busy, first_req, first_val, bad_grant;
    bit done;
    busy = 0; first_req = -1; first_val = -1; bad_grant = 0; done = 1'b0;
    push_src(2, 8'h41, 1'b0);
    push_src(2, 8'h42, 1'b1);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge i_clk);
      if (i_req_valid[2] && first_req < 0) first_req = c;
      if (o_valid && first_val < 0) first_val = c;
      if (o_busy) begin
        busy++;
        if (o_grant !== 4'b0100) bad_grant++;
      end
      if (c > 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL single_timeout: got pending=%0d expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (busy != 3) $display("FAIL single_busy_cycles: got %0d expected 3", busy); else n_pass++;
    n_checks++; if (bad_grant != 0) $display("FAIL single_grant: got %0d bad cycles expected 0", bad_grant); else n_pass++;
    n_checks++; if (first_val - first_req != 1) $display("FAIL single_latency: got %0d expected 1", first_val - first_req); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int gaps, gap_cur, gap_bad;
    bit started, prev_busy, done;
    gaps = 0; gap_cur = 0; gap_bad = 0; started = 1'b0; prev_busy = 1'b0; done = 1'b0;
    apply_reset();
    for (int k = 0; k < N; k++) begin
      push_src(k, 8'h10 + 8'(k), 1'b1);
      exp_q.push_back(8'hA0 + 8'(k));
      exp_q.push_back(8'h10 + 8'(k));
    end
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge i_clk);
      if (o_busy) begin
        if (started && !prev_busy) begin
          gaps++;
          if (gap_cur != 1) gap_bad++;
        end
        started = 1'b1;
        gap_cur = 0;
      end else if (started) gap_cur++;
      prev_busy = o_busy;
      if (c > 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL contention_timeout: got pending=%0d expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (gaps != 3) $display("FAIL contention_gaps: got %0d expected 3", gaps); else n_pass++;
    n_checks++; if (gap_bad != 0) $display("FAIL contention_gap_len: got %0d bad gaps expected 0", gap_bad); else n_pass++;
  endtask

  task automatic test_backpressure();
    int holds, stable_bad, ready_bad, accepts;
    bit prev_hold, done;
    logic [7:0] prev_data;
    holds = 0; stable_bad = 0; ready_bad = 0; accepts = 0; prev_hold = 1'b0; done = 1'b0;
    prev_data = 8'h00;
    rdy_mode = 1'b1;
    push_src(0, 8'h51, 1'b0); push_src(0, 8'h52, 1'b0); push_src(0, 8'h53, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h53);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge i_clk);
      if (prev_hold) begin
        holds++;
        if (!o_valid || o_data !== prev_data) stable_bad++;
      end
      if (o_req_ready != '0 && !i_ready) ready_bad++;
      if (o_req_ready[0] && i_ready && i_req_valid[0]) accepts++;
      prev_hold = o_valid && !i_ready;
      prev_data = o_data;
      if (c > 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    rdy_mode = 1'b0;
    n_checks++; if (!done) $display("FAIL bp_timeout: got pending=%0d expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (holds == 0) $display("FAIL bp_holds_seen: got %0d expected >0", holds); else n_pass++;
    n_checks++; if (stable_bad != 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_bad); else n_pass++;
    n_checks++; if (ready_bad != 0) $display("FAIL bp_ready_pulse: got %0d stray readies expected 0", ready_bad); else n_pass++;
    n_checks++; if (accepts != 3) $display("FAIL bp_accepts: got %0d expected 3", accepts); else n_pass++;
  endtask

  task automatic test_trunc();
    int x64_cyc, trunc_cyc, trunc_n, trunc_busy;
    logic [7:0] after_data;
    bit after_valid, done;
    x64_cyc = -1; trunc_cyc = -1; trunc_n = 0; trunc_busy = -1;
    after_data = 8'h00; after_valid = 1'b0; done = 1'b0;
    for (int i = 0; i < 6; i++) push_src(1, 8'h61 + 8'(i), (i == 5));
    exp_q.push_back(8'hA1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h61 + 8'(i));
    exp_q.push_back(8'hA1); exp_q.push_back(8'h65); exp_q.push_back(8'h66);
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge i_clk);
      if (o_valid && i_ready && o_data == 8'h64 && o_grant == 4'b0010) x64_cyc = c;
      if (trunc_cyc >= 0 && c == trunc_cyc + 1) begin
        after_valid = o_valid;
        after_data  = o_data;
      end
      if (o_trunc) begin
        trunc_n++;
        if (trunc_cyc < 0) begin
          trunc_cyc  = c;
          trunc_busy = int'(o_busy);
        end
      end
      if (c > 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL trunc_timeout: got pending=%0d expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (trunc_n != 1) $display("FAIL trunc_pulses: got %0d expected 1", trunc_n); else n_pass++;
    n_checks++; if (trunc_cyc - x64_cyc != 1) $display("FAIL trunc_timing: got %0d expected 1", trunc_cyc - x64_cyc); else n_pass++;
    n_checks++; if (trunc_busy != 0) $display("FAIL trunc_idle: got busy=%0d expected 0", trunc_busy); else n_pass++;
    n_checks++;
    if (!after_valid || after_data !== 8'hA1)
      $display("FAIL trunc_new_header: got v=%b d=%h expected v=1 d=a1", after_valid, after_data);
    else n_pass++;
  endtask

  task automatic test_stall();
    int found_c, stall_bad, trunc_n;
    bit done;
    found_c = -1; stall_bad = 0; trunc_n = 0; done = 1'b0;
    push_src(0, 8'h71, 1'b0); push_src(0, 8'h72, 1'b0);
    push_src(0, 8'h73, 1'b0); push_src(0, 8'h74, 1'b1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    exp_q.push_back(8'h73); exp_q.push_back(8'h74);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h7F);
    for (int c = 0; c < 20 && found_c < 0; c++) begin
      @(negedge i_clk);
      if (o_trunc) trunc_n++;
      if (o_valid && i_ready && o_data == 8'h72 && o_grant == 4'b0001) found_c = c;
    end
    n_checks++; if (found_c < 0) $display("FAIL stall_reach: got none expected byte 72 from src0"); else n_pass++;
    stall[0] = 1'b1;
    push_src(3, 8'h7F, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (o_trunc) trunc_n++;
      if (o_valid || o_req_ready[3] || o_grant !== 4'b0001) stall_bad++;
    end
    stall[0] = 1'b0;
    n_checks++; if (stall_bad != 0) $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); else n_pass++;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge i_clk);
      if (o_trunc) trunc_n++;
      if (c > 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL stall_timeout: got pending=%0d expected 0", exp_q.size()); else n_pass++;
    n_checks++; if (trunc_n != 0) $display("FAIL last_at_max_trunc: got %0d pulses expected 0", trunc_n); else n_pass++;
  endtask

  task automatic test_async_reset();
    int found_c;
    logic [N-1:0] first_grant;
    bit done;
    found_c = -1; first_grant = '0; done = 1'b0;
    push_src(1, 8'h91, 1'b0); push_src(1, 8'h92, 1'b0); push_src(1, 8'h93, 1'b1);
    push_src(2, 8'h88, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'h91); exp_q.push_back(8'h92); exp_q.push_back(8'h93);
    for (int c = 0; c < 20 && found_c < 0; c++) begin
      @(negedge i_clk);
      if (o_valid && o_data == 8'h92 && o_grant == 4'b0010) found_c = c;
    end
    n_checks++; if (found_c < 0) $display("FAIL arst_reach: got none expected byte 92 from src1"); else n_pass++;
    #2;
    i_rst_n = 1'b0;
    mon_en  = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_busy, o_trunc, o_grant, o_req_ready, o_data} !== '0)
      $display("FAIL arst_outputs: got v=%b b=%b t=%b g=%b r=%b d=%h expected all 0",
               o_valid, o_busy, o_trunc, o_grant, o_req_ready, o_data);
    else n_pass++;
    src_rd[1] = 0;
    src_wr[1] = 0;
    acc = '0;
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    mon_en  = 1'b1;
    exp_q.push_back(8'hA2); exp_q.push_back(8'h88);
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge i_clk);
      if (o_busy && first_grant == '0) first_grant = o_grant;
      if (c > 0 && exp_q.size() == 0 && !o_busy) done = 1'b1;
    end
    n_checks++; if (first_grant !== 4'b0100) $display("FAIL arst_first_grant: got %b expected 0100", first_grant); else n_pass++;
    n_checks++; if (!done) $display("FAIL arst_timeout: got pending=%0d expected 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    mon_en      = 1'b0;
    rdy_mode    = 1'b0;
    i_rst_n     = 1'b0;
    i_ready     = 1'b1;
    i_req_data  = '0;
    i_req_valid = '0;
    i_req_last  = '0;
    clear_srcs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_trunc();
    test_stall();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-serial UART emitter between N independent message sources.
- Round-robin arbitration at packet granularity: a grant is held from the first byte to the `last` byte, so messages never interleave on the serial line.
- Optionally prefixes each packet with a source-ID header byte.
- Enforces a maximum packet length so one stuck source cannot hold the line.
- Sits between the on-chip producers (status/log sources) and the UART emitter's data/valid/ready input.

Parameters:
- N_SRC, 4, number of requesters (1..8).
- HDR_EN, 1, 1 = insert header byte before each packet; 0 = no header.
- HDR_TAG, 5'b10100, upper 5 bits of the header byte; the lower 3 bits carry the source index.
- MAX_LEN, 64, maximum payload bytes per grant (1..255); the header byte is not counted.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_req_data  in  8*N_SRC  source bytes; source k occupies bits [8k+7:8k]
- i_req_valid  in  N_SRC  per-source byte valid
- i_req_last  in  N_SRC  per-source end-of-packet flag, qualified by valid
- o_req_ready  out  N_SRC  per-source accept; at most one bit set
- o_data  out  8  byte to the emitter
- o_valid  out  1  byte valid to the emitter
- i_ready  in  1  emitter ready; a transfer occurs when o_valid & i_ready
- o_grant  out  N_SRC  one-hot current owner; all zero in IDLE
- o_busy  out  1  high in HDR or SEND
- o_trunc  out  1  one-cycle pulse when a packet is cut at MAX_LEN

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, rr_ptr = 0, grant_idx = 0, byte count = 0.
  - All outputs 0, o_data = 0.
  - An assertion mid-packet abandons the packet immediately; there is no flush.
- FSM states are IDLE, HDR and SEND.
- IDLE:
  - o_valid = 0, o_req_ready = 0.
  - If any i_req_valid is set, select the first set bit searching from rr_ptr upward with wrap at N_SRC.
  - Register grant_idx and clear the count.
  - Next state is HDR if HDR_EN, else SEND.
- HDR:
  - o_valid = 1, o_data = {HDR_TAG, grant_idx[2:0]}, o_req_ready = 0.
  - On i_ready, go to SEND.
- SEND (combinational pass-through of the granted source):
  - o_data = i_req_data[grant_idx].
  - o_valid = i_req_valid[grant_idx].
  - o_req_ready[grant_idx] = i_ready; all other ready bits are 0.
  - Count increments on each transfer.
- Release:
  - Occurs on a transfer with i_req_last[grant_idx] = 1, or a transfer that makes count = MAX_LEN.
  - On release: next state IDLE, rr_ptr = (grant_idx+1) mod N_SRC.
  - If release is due to MAX_LEN and last = 0, pulse o_trunc in the following cycle. The source's remaining bytes later form a new packet with a new header.
- Latency:
  - Request in IDLE to o_valid: 1 cycle.
  - After release there is exactly one IDLE cycle before the next grant, even if requests are pending.
- Boundary conditions:
  - Granted source drops valid mid-packet: the grant is held, o_valid = 0, and no other source is served.
  - Non-granted valids are ignored and never receive ready.
  - Byte with last = 1 exactly at count MAX_LEN: normal release, no o_trunc.
  - N_SRC = 1: the arbiter degenerates to the same source every packet, and the header index is 0.
  - rr_ptr wraps from N_SRC-1 to 0.
  - The count is clog2(MAX_LEN+1) bits wide and saturates by construction (release at MAX_LEN).
- Stability: o_data and o_valid are not withdrawn by the arbiter while i_ready = 0, except when the source itself withdraws its valid.
- o_grant = onehot(grant_idx) in HDR and SEND.
- o_busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg: state encoding, HDR_TAG default, MAX_SRC = 8.
- One natural sub-module, rr_pick: combinational round-robin first-set finder taking req[N], ptr and returning idx and found. Reusable elsewhere.
- FSM, counter and muxes live in the top.

Test Plan:
- Single packet: HDR_EN = 1, src 2 sends 0x41, 0x42 (last), i_ready always 1 → o_data sequence 0xA2, 0x41, 0x42; o_grant = 4'b0100; o_busy high for 3 cycles.
- Contention: all 4 sources request 1-byte packets simultaneously, rr_ptr = 0 → headers 0xA0, 0xA1, 0xA2, 0xA3 in order, each followed by its byte, one idle cycle between packets.
- Backpressure: i_ready toggles 1/0 every cycle (emulating emitter busy) → each byte is held stable until accepted, and o_req_ready pulses only on accepted cycles.
- Truncation: MAX_LEN = 4, src 1 streams 6 bytes without last → 4 bytes, o_trunc pulse, 1 IDLE cycle, new header 0xA1, then the remaining 2 bytes.
- Source stall: granted src 0 drops valid for 5 cycles mid-packet while src 3 is valid → o_valid = 0 and o_req_ready[3] = 0 throughout; src 0 resumes and completes.
- Async reset mid-SEND: assert i_rst_n low between clock edges → outputs are 0 immediately; after release, src 2 pending gives first grant to src 2 with rr_ptr = 0.
